// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, ALUOp
// encodings, datapath select encodings, FSM state enumeration and the
// Moore control word produced for each state.
package mips_pkg;

    // Opcode field values recognised by the main controller
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALUOp encodings, also consumed by the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-input select encodings
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Next-PC select encodings
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Main FSM states; encodings 12..15 are unreachable
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // Raw per-state control word, before MemReady/reset gating of strobes
    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } ctrl_word_t;

    // True when the opcode belongs to the supported instruction subset
    function automatic logic op_is_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction/status inputs to the
// controller and every select and strobe it drives back.
interface mips_multicycle_ctrl_if;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       IllegalOp;

    // Controller side
    modport master (
        input  Op, Zero, MemReady,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, IllegalOp
    );

    // Datapath side
    modport slave (
        output Op, Zero, MemReady,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, IllegalOp
    );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Purely combinational Moore decode from FSM state to the raw control word.
// Unlisted fields stay 0; unreachable encodings decode to an all-zero word.
module mips_ctrl_outdec
    import mips_pkg::*;
(
    input  state_t     state,
    output ctrl_word_t cw
);

    // State-to-control-word lookup
    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.alusrcb = SRCB_FOUR;
                cw.aluop   = ALUOP_ADD;
                cw.pcsrc   = PCSRC_ALU;
                cw.irwrite = 1'b1;
                cw.pcwrite = 1'b1;
            end
            S_DECODE: begin
                cw.alusrcb = SRCB_IMMSH;
                cw.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = SRCB_IMM;
                cw.aluop   = ALUOP_ADD;
            end
            S_MEMREAD: begin
                cw.iord = 1'b1;
            end
            S_MEMWB: begin
                cw.memtoreg = 1'b1;
                cw.regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                cw.iord     = 1'b1;
                cw.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = SRCB_REGB;
                cw.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                cw.regdst   = 1'b1;
                cw.regwrite = 1'b1;
            end
            S_BRANCH: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = SRCB_REGB;
                cw.aluop   = ALUOP_SUB;
                cw.pcsrc   = PCSRC_ALUOUT;
                cw.branch  = 1'b1;
            end
            S_ADDIEXEC: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = SRCB_IMM;
                cw.aluop   = ALUOP_ADD;
            end
            S_ADDIWB: begin
                cw.regwrite = 1'b1;
            end
            S_JUMP: begin
                cw.pcsrc   = PCSRC_JUMP;
                cw.pcwrite = 1'b1;
            end
            default: begin
                cw = '0;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath. Holds the state register,
// next-state logic, MemReady gating, PC enable and the sticky illegal-opcode
// flag; per-state selects come from mips_ctrl_outdec.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
)(
    input  logic                   clk,
    input  logic                   rst_n,
    mips_multicycle_ctrl_if.master bus
);

    state_t     state_r;
    state_t     state_next_s;
    ctrl_word_t cw_s;
    logic       mem_ready_s;
    logic       fetch_gate_s;
    logic       illegal_r;
    logic       illegal_next_s;

    // With the handshake disabled, memory is taken as always ready
    assign mem_ready_s = USE_MEM_READY ? bus.MemReady : 1'b1;

    mips_ctrl_outdec u_outdec (
        .state (state_r),
        .cw    (cw_s)
    );

    // State register and sticky illegal-opcode flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_FETCH;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            illegal_r <= illegal_next_s;
        end
    end

    // Next-state selection; Op is only looked at in DECODE and MEMADR
    always_comb begin
        state_next_s   = S_FETCH;
        illegal_next_s = illegal_r;
        case (state_r)
            S_FETCH: begin
                if (mem_ready_s) begin
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: state_next_s = S_MEMADR;
                    OP_RTYPE:     state_next_s = S_EXECUTE;
                    OP_BEQ:       state_next_s = S_BRANCH;
                    OP_ADDI:      state_next_s = S_ADDIEXEC;
                    OP_J:         state_next_s = S_JUMP;
                    default:      state_next_s = S_FETCH;
                endcase
                if (!op_is_legal(bus.Op)) begin
                    illegal_next_s = 1'b1;
                end else begin
                    illegal_next_s = illegal_r;
                end
            end
            S_MEMADR: begin
                if (bus.Op == OP_LW) begin
                    state_next_s = S_MEMREAD;
                end else begin
                    state_next_s = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                if (mem_ready_s) begin
                    state_next_s = S_MEMWB;
                end else begin
                    state_next_s = S_MEMREAD;
                end
            end
            S_MEMWRITE: begin
                if (mem_ready_s) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_MEMWRITE;
                end
            end
            S_EXECUTE:  state_next_s = S_ALUWB;
            S_ADDIEXEC: state_next_s = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_next_s = S_FETCH;
            default:    state_next_s = S_FETCH;
        endcase
    end

    // In FETCH the IR and PC loads wait for the memory handshake
    always_comb begin
        if (state_r == S_FETCH) begin
            fetch_gate_s = mem_ready_s;
        end else begin
            fetch_gate_s = 1'b1;
        end
    end

    // Selects pass straight through; strobes are also forced low during reset
    assign bus.IorD      = cw_s.iord;
    assign bus.RegDst    = cw_s.regdst;
    assign bus.MemtoReg  = cw_s.memtoreg;
    assign bus.ALUSrcA   = cw_s.alusrca;
    assign bus.ALUSrcB   = cw_s.alusrcb;
    assign bus.ALUOp     = cw_s.aluop;
    assign bus.PCSrc     = cw_s.pcsrc;
    assign bus.IRWrite   = cw_s.irwrite & fetch_gate_s & rst_n;
    assign bus.MemWrite  = cw_s.memwrite & rst_n;
    assign bus.RegWrite  = cw_s.regwrite & rst_n;
    assign bus.PCEn      = ((cw_s.pcwrite & fetch_gate_s) | (cw_s.branch & bus.Zero)) & rst_n;
    assign bus.IllegalOp = illegal_r;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives every datapath select and write strobe, and produces the 2-bit ALUOp that feeds the ALU decoder. Memory accesses wait on a MemReady handshake, so the same FSM works with single-cycle or stalling memory.

Parameters:
USE_MEM_READY, 1, when 1 the Fetch/MemRead/MemWrite states wait for MemReady; when 0, MemReady is ignored and treated as 1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
Op  input  6  opcode field of the instruction register
Zero  input  1  ALU zero flag (valid in the Branch state)
MemReady  input  1  memory has completed the current access this cycle
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
RegDst  output  1  destination register: 0 = rt, 1 = rd
MemtoReg  output  1  writeback data: 0 = ALUOut, 1 = Data
RegWrite  output  1  register file write strobe
ALUSrcA  output  1  ALU A input: 0 = PC, 1 = register A
ALUSrcB  output  2  ALU B input: 00 = register B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
ALUOp  output  2  00 = add, 01 = subtract, 10 = use Funct (consumed by the ALU decoder)
PCSrc  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
PCEn  output  1  PC load: PCWrite | (Branch & Zero)
IllegalOp  output  1  sticky flag: an unsupported opcode has been decoded

Behaviour:
- State register is reset asynchronously by rst_n low to FETCH; IllegalOp is cleared to 0.
- Outputs are Moore-decoded from the state.
- Write strobes (IRWrite, MemWrite, RegWrite, PCEn) are additionally ANDed with rst_n, so they read 0 while reset is asserted.
- Any select output not listed for a state is 0.
- States, their asserted outputs, and transitions:
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite=MemReady, PCWrite=MemReady. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target is computed here). Next state by Op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEXEC
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH, with IllegalOp set to 1 on that edge.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMREAD if Op is lw, otherwise to MEMWRITE.
- MEMREAD: IorD=1. Waits for MemReady, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Goes to FETCH.
- MEMWRITE: IorD=1, MemWrite=1 held until MemReady. Goes to FETCH on MemReady.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Goes to FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Goes to FETCH.
- JUMP: PCSrc=10, PCWrite=1. Goes to FETCH.
- Latency with MemReady held at 1: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles. Each cycle with MemReady=0 in a memory state adds one cycle.
- Op is sampled only in DECODE and MEMADR. The IR is stable there because IRWrite is 0 outside FETCH.
- Reset asserted mid-instruction: the FSM returns to FETCH immediately, with no partial write strobe.
- Unreachable state encodings go to FETCH on the next clock.
- IllegalOp stays 1 until reset.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - ALUOp encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10), shared with the ALU decoder;
  - the state enumeration, 4-bit.
- One natural sub-module, mips_ctrl_outdec: purely combinational state-to-control-word decode. The FSM top keeps the state register, next-state logic, MemReady gating, PCEn and IllegalOp.

Test Plan:
- Reset with rst_n=0 during Op=000000: IRWrite=PCEn=RegWrite=MemWrite=0 and IllegalOp=0. After release with MemReady=1, the first cycle shows IorD=0, ALUSrcB=01, IRWrite=1, PCEn=1.
- R-type (Op=000000), MemReady=1: states go FETCH, DECODE, EXECUTE, ALUWB. ALUOp=10 in EXECUTE. RegWrite=1 with RegDst=1 in cycle 4. Back in FETCH at cycle 5.
- lw (100011) with MemReady=0 for 2 cycles in MEMREAD: IorD=1 is held 3 cycles. MEMWB then gives RegWrite=1, MemtoReg=1. Total 7 cycles.
- beq (000100): with Zero=1, BRANCH gives PCEn=1, PCSrc=01, ALUOp=01. With Zero=0, PCEn=0. Both take 3 cycles.
- sw (101011) and j (000010): MemWrite=1 exactly one cycle in MEMWRITE. JUMP gives PCSrc=10, PCEn=1.
- Illegal Op=111111: DECODE returns to FETCH, IllegalOp rises and stays 1 through the following lw. rst_n low clears it.
